// File: rtl/shift_pipe_n.sv
// shift_pipe_n: pipelined barrel shifter (LSL, LSR, ASR, ROR) with carry and zero flags.
//
// One registered stage per shift-amount bit; stage k shifts by 2^k when shamt[k] is set.
// All stages advance together when the output is empty or being consumed.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   input operands valid
//   in_ready   block can accept an input this cycle (combinational from out_ready/out_valid)
//   in_data    operand
//   in_shamt   shift amount, unsigned, 0..WIDTH-1
//   in_op      00=LSL 01=LSR 10=ASR 11=ROR
//   out_valid  result valid
//   out_ready  consumer accepts result this cycle
//   out_data   shifted result
//   out_carry  last bit shifted out (0 when shamt is 0; result MSB for ROR)
//   out_zero   out_data == 0
module shift_pipe_n #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_zero
);

  typedef enum logic [1:0] {
    OpLsl = 2'b00,
    OpLsr = 2'b01,
    OpAsr = 2'b10,
    OpRor = 2'b11
  } op_e;

  // Index 0 is the pipeline input, index k+1 is the register output of stage k.
  logic             valid_s [SHW+1];
  logic [WIDTH-1:0] data_s  [SHW+1];
  logic             carry_s [SHW+1];
  // The final stage has no consumer for shamt/op, so these stop one stage earlier.
  logic [SHW-1:0]   shamt_s [SHW];
  op_e              op_s    [SHW];

  logic adv;
  logic zero_q;

  assign adv      = ~valid_s[SHW] | out_ready;
  assign in_ready = adv;

  assign valid_s[0] = in_valid;
  assign data_s[0]  = in_data;
  assign carry_s[0] = 1'b0;
  assign shamt_s[0] = in_shamt;
  assign op_s[0]    = op_e'(in_op);

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    localparam int unsigned Sh = 2 ** k;

    logic [WIDTH-1:0] res;
    logic             cout;
    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic             carry_q;

    // A stage that does not shift passes the carry from earlier stages; the last stage
    // that shifts therefore determines the final carry.
    always_comb begin
      res  = data_s[k];
      cout = carry_s[k];
      if (shamt_s[k][k]) begin
        unique case (op_s[k])
          OpLsl: begin
            res  = data_s[k] << Sh;
            cout = data_s[k][WIDTH-Sh];
          end
          OpLsr: begin
            res  = data_s[k] >> Sh;
            cout = data_s[k][Sh-1];
          end
          OpAsr: begin
            res  = $signed(data_s[k]) >>> Sh;
            cout = data_s[k][Sh-1];
          end
          OpRor: begin
            res  = (data_s[k] >> Sh) | (data_s[k] << (WIDTH - Sh));
            // Rotated MSB comes from bit Sh-1 of the stage input.
            cout = data_s[k][Sh-1];
          end
        endcase
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        carry_q <= 1'b0;
      end else if (adv) begin
        valid_q <= valid_s[k];
        data_q  <= res;
        carry_q <= cout;
      end
    end

    assign valid_s[k+1] = valid_q;
    assign data_s[k+1]  = data_q;
    assign carry_s[k+1] = carry_q;

    if (k < SHW - 1) begin : g_fwd
      logic [SHW-1:0] shamt_q;
      op_e            op_q;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          shamt_q <= '0;
          op_q    <= OpLsl;
        end else if (adv) begin
          shamt_q <= shamt_s[k];
          op_q    <= op_s[k];
        end
      end

      assign shamt_s[k+1] = shamt_q;
      assign op_s[k+1]    = op_q;
    end else begin : g_zero
      // Zero flag is registered alongside the final data so it holds with it during stalls.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          zero_q <= 1'b0;
        end else if (adv) begin
          zero_q <= (res == '0);
        end
      end
    end
  end

  assign out_valid = valid_s[SHW];
  assign out_data  = data_s[SHW];
  assign out_carry = carry_s[SHW];
  assign out_zero  = zero_q;

endmodule

// File: tb/tb_shift_pipe_n.sv
module tb_shift_pipe_n;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned SHW   = 3;

  logic             clk       = 1'b0;
  logic             reset_n   = 1'b1;
  logic             in_valid  = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data   = '0;
  logic [SHW-1:0]   in_shamt  = '0;
  logic [1:0]       in_op     = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             out_carry;
  logic             out_zero;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       carry;
    logic       zero;
  } exp_t;

  typedef struct packed {
    logic [7:0] d;
    logic [2:0] n;
    logic [1:0] op;
    logic [7:0] ed;
    logic       ec;
    logic       ez;
  } vec_t;

  exp_t q[$];
  vec_t dir_vec [10];

  shift_pipe_n #(
    .WIDTH(WIDTH),
    .SHW  (SHW)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_shamt (in_shamt),
    .in_op    (in_op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_carry(out_carry),
    .out_zero (out_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: whole-word shifts, rotate via a doubled word, carry picked from the operand.
  function automatic exp_t model(input logic [7:0] d, input int n, input logic [1:0] op);
    exp_t             e;
    logic [15:0]      dd;
    logic signed [7:0] sd;
    sd = d;
    dd = {d, d} >> n;
    case (op)
      2'd0:    e.data = d << n;
      2'd1:    e.data = d >> n;
      2'd2:    e.data = sd >>> n;
      default: e.data = dd[7:0];
    endcase
    if (n == 0)        e.carry = 1'b0;
    else if (op == 0)  e.carry = d[8-n];
    else if (op == 3)  e.carry = e.data[7];
    else               e.carry = d[n-1];
    e.zero = (e.data == 8'h00);
    return e;
  endfunction

  task automatic test_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++;
    if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", out_data); end
    checks++;
    if ({out_carry, out_zero} !== 2'b00) begin
      errors++; $display("FAIL reset_flags: got %b%b expected 00", out_carry, out_zero);
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #4;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b expected 0", out_valid); end
    end
  endtask

  task automatic test_directed();
    int  t0;
    bit  found;
    dir_vec = '{
      '{8'h96, 3'd1, 2'd0, 8'h2c, 1'b1, 1'b0},
      '{8'h96, 3'd2, 2'd1, 8'h25, 1'b1, 1'b0},
      '{8'h96, 3'd2, 2'd2, 8'he5, 1'b1, 1'b0},
      '{8'h01, 3'd1, 2'd1, 8'h00, 1'b1, 1'b1},
      '{8'h96, 3'd4, 2'd3, 8'h69, 1'b0, 1'b0},
      '{8'h81, 3'd1, 2'd3, 8'hc0, 1'b1, 1'b0},
      '{8'ha5, 3'd0, 2'd0, 8'ha5, 1'b0, 1'b0},
      '{8'ha5, 3'd0, 2'd1, 8'ha5, 1'b0, 1'b0},
      '{8'ha5, 3'd0, 2'd2, 8'ha5, 1'b0, 1'b0},
      '{8'ha5, 3'd0, 2'd3, 8'ha5, 1'b0, 1'b0}
    };
    for (int v = 0; v < 10; v++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = dir_vec[v].d;
      in_shamt  = dir_vec[v].n;
      in_op     = dir_vec[v].op;
      #4;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL dir%0d_in_ready: got %b expected 1", v, in_ready); end
      t0    = cyc;
      found = 1'b0;
      for (int w = 0; w < 10 && !found; w++) begin
        @(negedge clk);
        in_valid = 1'b0;
        #4;
        if (out_valid === 1'b1) found = 1'b1;
      end
      checks++;
      if (!found) begin
        errors++; $display("FAIL dir%0d_timeout: got no out_valid expected one within 10 cycles", v);
      end else begin
        checks++;
        if (cyc - t0 != 3) begin
          errors++; $display("FAIL dir%0d_latency: got %0d expected 3", v, cyc - t0);
        end
        checks++;
        if (out_data !== dir_vec[v].ed) begin
          errors++; $display("FAIL dir%0d_data: got %h expected %h", v, out_data, dir_vec[v].ed);
        end
        checks++;
        if (out_carry !== dir_vec[v].ec) begin
          errors++; $display("FAIL dir%0d_carry: got %b expected %b", v, out_carry, dir_vec[v].ec);
        end
        checks++;
        if (out_zero !== dir_vec[v].ez) begin
          errors++; $display("FAIL dir%0d_zero: got %b expected %b", v, out_zero, dir_vec[v].ez);
        end
      end
      @(negedge clk);
      #4;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL dir%0d_dup: got %b expected 0", v, out_valid); end
    end
  endtask

  task automatic test_stream();
    int   sent = 0;
    int   got  = 0;
    bit   need_new = 1'b1;
    bit   prev_stall = 1'b0;
    bit   exp_ready;
    exp_t prev;
    exp_t e;
    q.delete();
    for (int c = 0; c < 300 && !(sent == 16 && got == 16); c++) begin
      @(negedge clk);
      if (sent < 16) begin
        if (need_new) begin
          in_data  = 8'($urandom);
          in_shamt = 3'($urandom_range(0, 7));
          in_op    = 2'($urandom_range(0, 3));
          need_new = 1'b0;
        end
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      out_ready = 1'($urandom_range(0, 1));
      #4;
      exp_ready = !(out_valid === 1'b1 && !out_ready);
      checks++;
      if (in_ready !== exp_ready) begin
        errors++; $display("FAIL stream_in_ready: got %b expected %b", in_ready, exp_ready);
      end
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || {out_data, out_carry, out_zero} !== prev) begin
          errors++;
          $display("FAIL stream_hold: got v=%b %h/%b/%b expected v=1 %h/%b/%b", out_valid,
                   out_data, out_carry, out_zero, prev.data, prev.carry, prev.zero);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL stream_extra: got %h expected no result", out_data);
        end else begin
          e = q.pop_front();
          if ({out_data, out_carry, out_zero} !== e) begin
            errors++;
            $display("FAIL stream_result%0d: got %h/%b/%b expected %h/%b/%b", got, out_data,
                     out_carry, out_zero, e.data, e.carry, e.zero);
          end
        end
        got++;
      end
      prev_stall = (out_valid === 1'b1) && !out_ready;
      prev       = {out_data, out_carry, out_zero};
      if (in_valid && in_ready === 1'b1) begin
        q.push_back(model(in_data, int'(in_shamt), in_op));
        sent++;
        need_new = 1'b1;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (got != 16 || q.size() != 0) begin
      errors++; $display("FAIL stream_count: got %0d results expected 16 (pending %0d)", got, q.size());
    end
  endtask

  task automatic test_stall();
    exp_t exp_s [3];
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'($urandom);
      in_shamt  = 3'($urandom_range(1, 7));
      in_op     = 2'($urandom_range(0, 3));
      exp_s[i]  = model(in_data, int'(in_shamt), in_op);
      #4;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_fill%0d: got %b expected 1", i, in_ready); end
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #4;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++; $display("FAIL stall_hs%0d: got v=%b r=%b expected v=1 r=0", i, out_valid, in_ready);
      end
      checks++;
      if ({out_data, out_carry, out_zero} !== exp_s[0]) begin
        errors++; $display("FAIL stall_hold%0d: got %h/%b/%b expected %h/%b/%b", i, out_data,
                           out_carry, out_zero, exp_s[0].data, exp_s[0].carry, exp_s[0].zero);
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      out_ready = 1'b1;
      #4;
      checks++;
      if (out_valid !== 1'b1 || {out_data, out_carry, out_zero} !== exp_s[i]) begin
        errors++; $display("FAIL stall_drain%0d: got v=%b %h/%b/%b expected v=1 %h/%b/%b", i,
                           out_valid, out_data, out_carry, out_zero, exp_s[i].data,
                           exp_s[i].carry, exp_s[i].zero);
      end
    end
    @(negedge clk);
    #4;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_empty: got %b expected 0", out_valid); end
  endtask

  task automatic test_reset_inflight();
    exp_t e;
    int   t0;
    bit   found;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = (i == 0) ? 8'hf0 : 8'($urandom);
      in_shamt  = (i == 0) ? 3'd0 : 3'($urandom_range(0, 7));
      in_op     = 2'($urandom_range(0, 3));
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hf0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL rst_pre: got v=%b d=%h r=%b expected v=1 d=f0 r=0", out_valid,
                         out_data, in_ready);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00) begin
      errors++; $display("FAIL rst_now: got v=%b d=%h expected v=0 d=00", out_valid, out_data);
    end
    checks++;
    if ({out_carry, out_zero, in_ready} !== 3'b001) begin
      errors++; $display("FAIL rst_now_flags: got c=%b z=%b r=%b expected 0 0 1", out_carry,
                         out_zero, in_ready);
    end
    repeat (2) @(negedge clk);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #4;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_ghost%0d: got %b expected 0", i, out_valid); end
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'($urandom);
    in_shamt = 3'($urandom_range(0, 7));
    in_op    = 2'($urandom_range(0, 3));
    e        = model(in_data, int'(in_shamt), in_op);
    #4;
    t0    = cyc;
    found = 1'b0;
    for (int w = 0; w < 10 && !found; w++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #4;
      if (out_valid === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found || cyc - t0 != 3) begin
      errors++; $display("FAIL rst_after_latency: got found=%b lat=%0d expected found=1 lat=3", found,
                         cyc - t0);
    end
    checks++;
    if ({out_data, out_carry, out_zero} !== e) begin
      errors++; $display("FAIL rst_after_data: got %h/%b/%b expected %h/%b/%b", out_data, out_carry,
                         out_zero, e.data, e.carry, e.zero);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stream();
    test_stall();
    test_reset_inflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
